alu_seq: RTL and testbench

- Parametrised, registered, multi-cycle successor to the combinational datapath ALU. Same eight operations, generalised to WIDTH bits.
- Adds valid/ready handshakes on input and output, status flags, and an area-cheap iterative shifter: one bit position per cycle.
- Sits between operand fetch and writeback. It holds one operation at a time and stalls upstream while busy.

---
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with valid/ready handshakes and status flags.
// Holds one operation at a time. Shifts by 1..WIDTH-1 iterate one bit per cycle.
module alu_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [WIDTH-1:0] InputA,
   input  logic [WIDTH-1:0] InputB,
   input  logic [2:0]       OP,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [WIDTH-1:0] Out,
   output logic             Zero,
   output logic             Neg,
   output logic             Carry,
   output logic             Ovf
);

   localparam logic [2:0] OpAdd = 3'd0;
   localparam logic [2:0] OpSub = 3'd1;
   localparam logic [2:0] OpAnd = 3'd2;
   localparam logic [2:0] OpOrr = 3'd3;
   localparam logic [2:0] OpXor = 3'd4;
   localparam logic [2:0] OpRxr = 3'd5;
   localparam logic [2:0] OpLsl = 3'd6;
   localparam logic [2:0] OpLsr = 3'd7;

   localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

   state_t           state;
   logic [WIDTH-1:0] result;
   logic             flag_z;
   logic             flag_n;
   logic             flag_c;
   logic             flag_v;
   logic [CNT_W-1:0] cnt;
   logic             shift_left;
   logic             in_ready;
   logic             out_valid;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] res;
   logic             res_c;
   logic             res_v;
   logic             iterate;
   logic [WIDTH-1:0] step;
   logic             step_c;

   // Single-cycle result for every op; shifts here only cover n == 0 and n >= WIDTH.
   always_comb begin
      sum   = {1'b0, InputA} + {1'b0, InputB};
      diff  = {1'b0, InputA} - {1'b0, InputB};
      res   = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      unique case (OP)
         OpAdd: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (InputA[WIDTH-1] == InputB[WIDTH-1]) && (res[WIDTH-1] != InputA[WIDTH-1]);
         end
         OpSub: begin
            res   = diff[WIDTH-1:0];
            res_c = diff[WIDTH];
            res_v = (InputA[WIDTH-1] != InputB[WIDTH-1]) && (res[WIDTH-1] != InputA[WIDTH-1]);
         end
         OpAnd: res = InputA & InputB;
         OpOrr: res = InputA | InputB;
         OpXor: res = InputA ^ InputB;
         OpRxr: res = {{(WIDTH - 1){1'b0}}, ^InputA};
         OpLsl, OpLsr: res = (InputB == '0) ? InputA : '0;
      endcase
   end

   // Shift amounts in 1..WIDTH-1 take the iterative path.
   always_comb begin
      iterate = (OP == OpLsl || OP == OpLsr) && (InputB != '0) && (InputB < WidthVal);
   end

   // One-position shift of the working register; carry is the bit falling off.
   always_comb begin
      if (shift_left) begin
         step   = {result[WIDTH-2:0], 1'b0};
         step_c = result[WIDTH-1];
      end else begin
         step   = {1'b0, result[WIDTH-1:1]};
         step_c = result[0];
      end
   end

   // Control FSM with registered result, flags and handshake outputs.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state      <= StIdle;
         result     <= '0;
         flag_z     <= 1'b0;
         flag_n     <= 1'b0;
         flag_c     <= 1'b0;
         flag_v     <= 1'b0;
         cnt        <= '0;
         shift_left <= 1'b0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (In_Valid) begin
                  shift_left <= (OP == OpLsl);
                  in_ready   <= 1'b0;
                  if (iterate) begin
                     result <= InputA;
                     cnt    <= CNT_W'(InputB);
                     flag_c <= 1'b0;
                     flag_v <= 1'b0;
                     state  <= StShift;
                  end else begin
                     result    <= res;
                     flag_z    <= (res == '0);
                     flag_n    <= res[WIDTH-1];
                     flag_c    <= res_c;
                     flag_v    <= res_v;
                     out_valid <= 1'b1;
                     state     <= StDone;
                  end
               end
            end
            StShift: begin
               result <= step;
               flag_z <= (step == '0);
               flag_n <= step[WIDTH-1];
               flag_c <= step_c;
               cnt    <= cnt - CNT_W'(1);
               // Counter hits zero after this edge: last shift done.
               if (cnt == CNT_W'(1)) begin
                  out_valid <= 1'b1;
                  state     <= StDone;
               end
            end
            StDone: begin
               if (Out_Ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= StIdle;
            end
         endcase
      end
   end

   assign In_Ready  = in_ready;
   assign Out_Valid = out_valid;
   assign Out       = result;
   assign Zero      = flag_z;
   assign Neg       = flag_n;
   assign Carry     = flag_c;
   assign Ovf       = flag_v;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: table of vectors over WIDTH=8 and WIDTH=16 instances,
// scoreboard queue of expected results, plus backpressure and mid-shift reset sequences.
module tb_alu_seq;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, ORR = 3'd3;
   localparam logic [2:0] XOR = 3'd4, RXR = 3'd5, LSL = 3'd6, LSR = 3'd7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       iv8 = 1'b0, or8 = 1'b0, ir8, ov8, z8, n8, c8, v8;
   logic [7:0] a8 = '0, b8 = '0, out8;
   logic [2:0] op8 = '0;

   logic        iv16 = 1'b0, or16 = 1'b0, ir16, ov16, z16, n16, c16, v16;
   logic [15:0] a16 = '0, b16 = '0, out16;
   logic [2:0]  op16 = '0;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit          w16;
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] out;
      logic        z, n, c, v;
      int          lat;
   } vec_t;

   typedef struct {
      logic [15:0] out;
      logic        z, n, c, v;
      int          lat;
      int          id;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8)) u_dut8 (
      .Clk(clk), .Reset_n(rst_n), .In_Valid(iv8), .In_Ready(ir8), .InputA(a8), .InputB(b8),
      .OP(op8), .Out_Valid(ov8), .Out_Ready(or8), .Out(out8), .Zero(z8), .Neg(n8),
      .Carry(c8), .Ovf(v8)
   );

   alu_seq #(.WIDTH(16)) u_dut16 (
      .Clk(clk), .Reset_n(rst_n), .In_Valid(iv16), .In_Ready(ir16), .InputA(a16),
      .InputB(b16), .OP(op16), .Out_Valid(ov16), .Out_Ready(or16), .Out(out16), .Zero(z16),
      .Neg(n16), .Carry(c16), .Ovf(v16)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic rdy(input bit w16);
      return w16 ? ir16 : ir8;
   endfunction

   function automatic logic vld(input bit w16);
      return w16 ? ov16 : ov8;
   endfunction

   function automatic exp_t sample(input bit w16);
      exp_t s;
      s.out = w16 ? out16 : {8'h00, out8};
      s.z   = w16 ? z16 : z8;
      s.n   = w16 ? n16 : n8;
      s.c   = w16 ? c16 : c8;
      s.v   = w16 ? v16 : v8;
      s.lat = 0;
      s.id  = 0;
      return s;
   endfunction

   task automatic drive(input bit w16, input logic iv, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b);
      if (w16) begin
         iv16 = iv; op16 = op; a16 = a; b16 = b;
      end else begin
         iv8 = iv; op8 = op; a8 = a[7:0]; b8 = b[7:0];
      end
   endtask

   task automatic set_ready(input bit w16, input logic r);
      if (w16) or16 = r;
      else or8 = r;
   endtask

   function automatic void add(input bit w16, input logic [2:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] out, input logic z,
                               input logic n, input logic c, input logic v, input int lat);
      vec_t t;
      t.w16 = w16; t.op = op; t.a = a; t.b = b; t.out = out;
      t.z = z; t.n = n; t.c = c; t.v = v; t.lat = lat;
      vecs.push_back(t);
   endfunction

   // Issue one op, wait (bounded) for its result, check against the scoreboard, then drain.
   task automatic run_op(input vec_t t, input int id);
      exp_t e, got;
      int   cyc;
      cyc = 0;
      while (!rdy(t.w16) && cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      chk($sformatf("v%0d_ready_before_issue", id), {31'b0, rdy(t.w16)}, 32'd1);
      drive(t.w16, 1'b1, t.op, t.a, t.b);
      e.out = t.out; e.z = t.z; e.n = t.n; e.c = t.c; e.v = t.v; e.lat = t.lat; e.id = id;
      sb.push_back(e);
      @(posedge clk); #1;
      drive(t.w16, 1'b0, t.op, 16'h0, 16'h0);
      cyc = 1;
      while (!vld(t.w16) && cyc < 64) begin
         chk($sformatf("v%0d_in_ready_low_busy", id), {31'b0, rdy(t.w16)}, 32'd0);
         @(posedge clk); #1; cyc++;
      end
      chk($sformatf("v%0d_out_valid", id), {31'b0, vld(t.w16)}, 32'd1);
      got = sample(t.w16);
      if (sb.size() == 0) begin
         chk($sformatf("v%0d_scoreboard_nonempty", id), 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk($sformatf("v%0d_out", e.id), {16'h0, got.out}, {16'h0, e.out});
         chk($sformatf("v%0d_zero", e.id), {31'b0, got.z}, {31'b0, e.z});
         chk($sformatf("v%0d_neg", e.id), {31'b0, got.n}, {31'b0, e.n});
         chk($sformatf("v%0d_carry", e.id), {31'b0, got.c}, {31'b0, e.c});
         chk($sformatf("v%0d_ovf", e.id), {31'b0, got.v}, {31'b0, e.v});
         chk($sformatf("v%0d_latency", e.id), cyc, e.lat);
      end
      chk($sformatf("v%0d_in_ready_done", id), {31'b0, rdy(t.w16)}, 32'd0);
      set_ready(t.w16, 1'b1);
      @(posedge clk); #1;
      set_ready(t.w16, 1'b0);
      chk($sformatf("v%0d_valid_dropped", id), {31'b0, vld(t.w16)}, 32'd0);
      chk($sformatf("v%0d_back_to_idle", id), {31'b0, rdy(t.w16)}, 32'd1);
   endtask

   initial begin
      vec_t t;
      exp_t s;
      int   hi;

      //   w16 op   a         b         out       z  n  c  v  lat
      add(0, ADD, 16'h007F, 16'h0001, 16'h0080, 0, 1, 0, 1, 1);
      add(0, ADD, 16'h00FF, 16'h0001, 16'h0000, 1, 0, 1, 0, 1);
      add(0, SUB, 16'h0005, 16'h0007, 16'h00FE, 0, 1, 1, 0, 1);
      add(0, SUB, 16'h0080, 16'h0001, 16'h007F, 0, 0, 0, 1, 1);
      add(0, SUB, 16'h0033, 16'h0033, 16'h0000, 1, 0, 0, 0, 1);
      add(0, RXR, 16'h0007, 16'h0055, 16'h0001, 0, 0, 0, 0, 1);
      add(0, AND, 16'h00F0, 16'h003C, 16'h0030, 0, 0, 0, 0, 1);
      add(0, ORR, 16'h00F0, 16'h000F, 16'h00FF, 0, 1, 0, 0, 1);
      add(0, XOR, 16'h00AA, 16'h00FF, 16'h0055, 0, 0, 0, 0, 1);
      add(0, LSR, 16'h000D, 16'h0003, 16'h0001, 0, 0, 1, 0, 4);
      add(0, LSL, 16'h0081, 16'h0003, 16'h0008, 0, 0, 0, 0, 4);
      add(0, LSL, 16'h005A, 16'h0000, 16'h005A, 0, 0, 0, 0, 1);
      add(0, LSL, 16'h00FF, 16'h0009, 16'h0000, 1, 0, 0, 0, 1);
      add(0, LSR, 16'h00FF, 16'h0008, 16'h0000, 1, 0, 0, 0, 1);
      add(0, LSR, 16'h00C0, 16'h0007, 16'h0001, 0, 0, 1, 0, 8);
      add(0, LSL, 16'h0003, 16'h0007, 16'h0080, 0, 1, 1, 0, 8);
      add(1, LSR, 16'h8000, 16'h000F, 16'h0001, 0, 0, 0, 0, 16);
      add(1, ADD, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1, 1);
      add(1, LSL, 16'h00FF, 16'h0004, 16'h0FF0, 0, 0, 0, 0, 5);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out8", {24'h0, out8}, 32'h0);
      chk("reset_flags8", {28'h0, z8, n8, c8, v8}, 32'h0);
      chk("reset_valid8", {31'b0, ov8}, 32'd0);
      chk("reset_ready8", {31'b0, ir8}, 32'd1);
      chk("reset_out16", {16'h0, out16}, 32'h0);
      chk("reset_flags16", {28'h0, z16, n16, c16, v16}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) run_op(vecs[i], i);

      // Backpressure: result and flags hold while Out_Ready is low; stray issue ignored
      t.w16 = 0; t.op = ADD; t.a = 16'h0010; t.b = 16'h0020;
      drive(0, 1'b1, ADD, 16'h0010, 16'h0020);
      @(posedge clk); #1;
      drive(0, 1'b0, ADD, 16'h0, 16'h0);
      chk("bp_valid", {31'b0, ov8}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         if (k == 1) drive(0, 1'b1, SUB, 16'h0001, 16'h0009);
         if (k == 2) drive(0, 1'b0, ADD, 16'h0, 16'h0);
         s = sample(0);
         chk($sformatf("bp_out_c%0d", k), {16'h0, s.out}, 32'h30);
         chk($sformatf("bp_flags_c%0d", k), {28'h0, s.z, s.n, s.c, s.v}, 32'h0);
         chk($sformatf("bp_valid_c%0d", k), {30'b0, ov8, ir8}, 32'h2);
         @(posedge clk); #1;
      end
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
      chk("bp_idle", {30'b0, ov8, ir8}, 32'h1);
      chk("bp_out_hold", {24'h0, out8}, 32'h30);
      // Out_Ready while idle must not disturb anything
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
      chk("bp_ready_idle_noeffect", {30'b0, ov8, ir8}, 32'h1);
      add(0, SUB, 16'h0009, 16'h0004, 16'h0005, 0, 0, 0, 0, 1);
      run_op(vecs[vecs.size() - 1], 100);

      // Reset mid-shift: aborted shift must produce nothing
      drive(0, 1'b1, LSL, 16'h0001, 16'h0006);
      @(posedge clk); #1;
      drive(0, 1'b0, ADD, 16'h0, 16'h0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("rs_busy_before_reset", {31'b0, ir8}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rs_out", {24'h0, out8}, 32'h0);
      chk("rs_flags", {28'h0, z8, n8, c8, v8}, 32'h0);
      chk("rs_valid", {31'b0, ov8}, 32'd0);
      chk("rs_ready", {31'b0, ir8}, 32'd1);
      hi = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (ov8) hi++;
      end
      chk("rs_no_stale_valid", hi, 0);
      add(0, ADD, 16'h0002, 16'h0003, 16'h0005, 0, 0, 0, 0, 1);
      run_op(vecs[vecs.size() - 1], 101);

      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
